rf_scoreboard: RTL and testbench
================================

// Module: rf_scoreboard
// PURPOSE
//  Parametrised 2-read/1-write register file for the datapath, with a per-register
//  busy scoreboard for multi-cycle producers (loads, mul/div). Sits between
//  decode (read + busy check) and writeback (write + busy clear). Adds async
//  reset clearing, configurable width/depth, optional hardwired zero register
//  and an optional write-to-read bypass.
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; depth = 2**AW registers
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy; 0: ordinary register
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   asynchronous reset, active high
//  we         in   1   write enable
//  wa_i       in   AW  write address
//  wd_i       in   DW  write data
//  ra0_i      in   AW  read address, port 0
//  ra1_i      in   AW  read address, port 1
//  rd0_o      out  DW  read data, port 0 (combinational)
//  rd1_o      out  DW  read data, port 1 (combinational)
//  bset_i     in   1   mark register bwa_i busy (producer issued)
//  bwa_i      in   AW  busy-set address
//  busy0_o    out  1   register ra0_i is busy (combinational)
//  busy1_o    out  1   register ra1_i is busy (combinational)
//  nbusy_o    out  AW+1 count of busy registers (registered)
// BEHAVIOUR
//  - Reset (rst=1, async): all registers = 0, all busy bits = 0, nbusy_o = 0;
//    rd*_o = 0 and busy*_o = 0 while held. we/bset_i ignored while rst=1.
//    Reset mid-operation discards pending writes and busy state.
//  - Write: on posedge clk with we=1, regs[wa_i] <= wd_i. ZERO_REG=1 and wa_i=0:
//    no update. Write latency 1 cycle; no bypass unless macro below.
//  - Read: rd_n = regs[ra_n]; ZERO_REG=1 and ra_n=0 -> 0. Both ports may read
//    the same address.
//  - Busy set: posedge with bset_i=1 -> busy[bwa_i] <= 1 (not for reg 0 when ZERO_REG=1).
//  - Busy clear: posedge with we=1 -> busy[wa_i] <= 0.
//  - Same address set and clear in one cycle: set wins (new producer supersedes).
//  - Set on already-busy reg: stays busy, count unchanged. Clear on non-busy: no-op.
//  - nbusy_o tracks popcount of busy bits, updated same edge as bits: +1 set-only
//    on idle reg, -1 clear-only on busy reg, net 0 set+clear same busy reg, +1 set
//    on idle reg with clear on a different busy reg -> net 0, etc. Range 0..2**AW
//    (no wrap; width AW+1).
// CONFIGURATION
//  RF_BYPASS_EN defined: when we=1 and wa_i==ra_n (and not zero reg under
//    ZERO_REG=1), rd_n = wd_i in the same cycle, and busy_n = 0 unless bset_i=1
//    with bwa_i==ra_n the same cycle. Combinational path we/wa_i/wd_i -> rd*_o.
//  RF_BYPASS_EN undefined: rd_n returns the pre-write value in the write cycle,
//    new value from the next cycle; busy_n shows pre-edge state.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> rd0_o(ra0=5)=0,
//    nbusy_o=0 immediately, stays 0 after release.
//  2 Zero reg: ZERO_REG=1, we=1 wa=0 wd=0x1234, bset bwa=0 -> rd(0)=0, busy0_o=0,
//    nbusy_o=0; ZERO_REG=0 same stimulus -> rd(0)=0x1234 next cycle.
//  3 Read/write: write r3=0xA5A5_0001, ra0=ra1=3 -> both ports 0xA5A5_0001 the
//    cycle after; same-cycle value is old (0) without macro, new with RF_BYPASS_EN.
//  4 Scoreboard: bset r7, r9 -> nbusy_o=2, busy0_o(ra0=7)=1; write r7 -> busy
//    r7=0, nbusy_o=1; write r4 (not busy) -> nbusy_o stays 1.
//  5 Collision: r2 busy; same cycle bset bwa=2 and we wa=2 -> r2 updated, busy
//    stays 1, nbusy_o unchanged; set r6 + clear r2 same cycle -> count unchanged.
//  6 Saturation: AW=3, set all 8 regs (ZERO_REG=0) -> nbusy_o=8, extra sets keep 8;
//    write all 8 -> nbusy_o=0, no underflow on further writes.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// Bus between decode/writeback and the register file: write port, two read ports,
// busy-set request and the busy scoreboard outputs.
interface rf_scoreboard_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic          bset;
  logic [AW-1:0] bwa;
  logic          busy0;
  logic          busy1;
  logic [AW:0]   nbusy;

  modport master (
    output we, wa, wd, ra0, ra1, bset, bwa,
    input  rd0, rd1, busy0, busy1, nbusy
  );

  modport slave (
    input  we, wa, wd, ra0, ra1, bset, bwa,
    output rd0, rd1, busy0, busy1, nbusy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// 2-read/1-write register file with per-register busy scoreboard and busy count.
// Define RF_BYPASS_EN to forward the same-cycle write (data and busy clear) to the read ports.
module rf_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic            clk,
  input logic            rst,
  rf_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [AW:0]      nbusy_reg;
  logic             inc;
  logic             dec;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit HARD_ZERO = ZERO_REG && (gi == 0);

      assign set_vec[gi] = !HARD_ZERO && bus.bset && (bus.bwa == AW'(gi));
      assign clr_vec[gi] = bus.we && (bus.wa == AW'(gi));

      // A new producer issued in the same cycle supersedes the retiring one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi]     <= '0;
          busy_vec[gi] <= 1'b0;
        end else begin
          if (clr_vec[gi] && !HARD_ZERO) begin
            regs[gi] <= bus.wd;
          end
          if (set_vec[gi]) begin
            busy_vec[gi] <= 1'b1;
          end else if (clr_vec[gi]) begin
            busy_vec[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // At most one set and one clear per cycle, so the count moves by -1, 0 or +1.
  assign inc = |(set_vec & ~busy_vec);
  assign dec = |(clr_vec & busy_vec & ~set_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbusy_reg <= '0;
    end else begin
      nbusy_reg <= nbusy_reg + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

  assign bus.nbusy = nbusy_reg;

  logic [AW-1:0] ra [2];
  assign ra[0] = bus.ra0;
  assign ra[1] = bus.ra1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] rd_val;
      logic          busy_val;
      logic          hard_zero;

      assign hard_zero = ZERO_REG && (ra[gi] == '0);

      always_comb begin
        rd_val   = regs[ra[gi]];
        busy_val = busy_vec[ra[gi]];
`ifdef RF_BYPASS_EN
        if (bus.we && (bus.wa == ra[gi])) begin
          rd_val   = bus.wd;
          busy_val = bus.bset && (bus.bwa == ra[gi]);
        end
`else
`endif
        if (hard_zero || rst) begin
          rd_val   = '0;
          busy_val = 1'b0;
        end
      end
    end
  endgenerate

  assign bus.rd0   = g_port[0].rd_val;
  assign bus.rd1   = g_port[1].rd_val;
  assign bus.busy0 = g_port[0].busy_val;
  assign bus.busy1 = g_port[1].busy_val;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: three instances (AW=5 with/without zero reg, AW=3 no zero reg).
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rf_scoreboard_if #(.DW(32), .AW(5)) ifa ();
  rf_scoreboard_if #(.DW(32), .AW(5)) ifb ();
  rf_scoreboard_if #(.DW(32), .AW(3)) ifc ();

  rf_scoreboard #(.DW(32), .AW(5), .ZERO_REG(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rf_scoreboard #(.DW(32), .AW(5), .ZERO_REG(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  rf_scoreboard #(.DW(32), .AW(3), .ZERO_REG(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.we = 0; ifa.wa = '0; ifa.wd = '0; ifa.ra0 = '0; ifa.ra1 = '0; ifa.bset = 0; ifa.bwa = '0;
    ifb.we = 0; ifb.wa = '0; ifb.wd = '0; ifb.ra0 = '0; ifb.ra1 = '0; ifb.bset = 0; ifb.bwa = '0;
    ifc.we = 0; ifc.wa = '0; ifc.wd = '0; ifc.ra0 = '0; ifc.ra1 = '0; ifc.bset = 0; ifc.bwa = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    ifa.ra0 = 5'd5;
    #1;
    chk("rst_held_rd0", ifa.rd0, 0);
    chk("rst_held_nbusy", ifa.nbusy, 0);
    rst = 1'b0;
    tick();

    // reset mid-operation
    ifa.we = 1; ifa.wa = 5'd5; ifa.wd = 32'hDEADBEEF; ifa.bset = 1; ifa.bwa = 5'd6;
    tick();
    ifa.we = 0; ifa.bset = 0;
    #1;
    chk("t1_rd0_r5", ifa.rd0, 32'hDEADBEEF);
    chk("t1_nbusy", ifa.nbusy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_rd0", ifa.rd0, 0);
    chk("t1_async_nbusy", ifa.nbusy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    ifa.ra1 = 5'd6;
    #1;
    chk("t1_after_rd0", ifa.rd0, 0);
    chk("t1_after_nbusy", ifa.nbusy, 0);
    chk("t1_after_busy_r6", ifa.busy1, 0);

    // zero register, with and without hardwiring
    ifa.we = 1; ifa.wa = '0; ifa.wd = 32'h1234; ifa.bset = 1; ifa.bwa = '0; ifa.ra0 = '0;
    ifb.we = 1; ifb.wa = '0; ifb.wd = 32'h1234; ifb.bset = 1; ifb.bwa = '0; ifb.ra0 = '0;
    #1;
    chk("t2_a_same_rd0", ifa.rd0, 0);
    chk("t2_a_same_busy0", ifa.busy0, 0);
    chk("t2_b_same_rd0", ifb.rd0, BYP ? 32'h1234 : 32'h0);
    chk("t2_b_same_busy0", ifb.busy0, BYP ? 1 : 0);
    tick();
    ifa.we = 0; ifa.bset = 0; ifb.we = 0; ifb.bset = 0;
    #1;
    chk("t2_a_rd0", ifa.rd0, 0);
    chk("t2_a_busy0", ifa.busy0, 0);
    chk("t2_a_nbusy", ifa.nbusy, 0);
    chk("t2_b_rd0", ifb.rd0, 32'h1234);
    chk("t2_b_busy0", ifb.busy0, 1);
    chk("t2_b_nbusy", ifb.nbusy, 1);
    ifb.we = 1; ifb.wa = '0; ifb.wd = 32'h1234;
    tick();
    ifb.we = 0;
    #1;
    chk("t2_b_clr_nbusy", ifb.nbusy, 0);
    chk("t2_b_clr_busy0", ifb.busy0, 0);

    // read/write latency, both ports on one address
    ifa.we = 1; ifa.wa = 5'd3; ifa.wd = 32'hA5A5_0001; ifa.ra0 = 5'd3; ifa.ra1 = 5'd3;
    #1;
    chk("t3_same_rd0", ifa.rd0, BYP ? 32'hA5A5_0001 : 32'h0);
    chk("t3_same_rd1", ifa.rd1, BYP ? 32'hA5A5_0001 : 32'h0);
    tick();
    ifa.we = 0;
    #1;
    chk("t3_rd0", ifa.rd0, 32'hA5A5_0001);
    chk("t3_rd1", ifa.rd1, 32'hA5A5_0001);

    // scoreboard set/clear
    ifa.bset = 1; ifa.bwa = 5'd7;
    tick();
    ifa.bwa = 5'd9;
    tick();
    ifa.bset = 0; ifa.ra0 = 5'd7; ifa.ra1 = 5'd9;
    #1;
    chk("t4_nbusy2", ifa.nbusy, 2);
    chk("t4_busy_r7", ifa.busy0, 1);
    chk("t4_busy_r9", ifa.busy1, 1);
    ifa.we = 1; ifa.wa = 5'd7; ifa.wd = 32'h77;
    #1;
    chk("t4_same_busy_r7", ifa.busy0, BYP ? 0 : 1);
    tick();
    ifa.we = 0;
    #1;
    chk("t4_clr_busy_r7", ifa.busy0, 0);
    chk("t4_clr_nbusy", ifa.nbusy, 1);
    chk("t4_rd_r7", ifa.rd0, 32'h77);
    ifa.we = 1; ifa.wa = 5'd4; ifa.wd = 32'h44;
    tick();
    ifa.we = 0;
    #1;
    chk("t4_idle_clr_nbusy", ifa.nbusy, 1);

    // collisions
    ifa.bset = 1; ifa.bwa = 5'd2;
    tick();
    ifa.bset = 0;
    #1;
    chk("t5_nbusy2", ifa.nbusy, 2);
    ifa.bset = 1; ifa.bwa = 5'd2; ifa.we = 1; ifa.wa = 5'd2; ifa.wd = 32'h22; ifa.ra0 = 5'd2;
    #1;
    chk("t5_same_busy_r2", ifa.busy0, 1);
    tick();
    ifa.bset = 0; ifa.we = 0;
    #1;
    chk("t5_rd_r2", ifa.rd0, 32'h22);
    chk("t5_busy_r2", ifa.busy0, 1);
    chk("t5_nbusy_setclr", ifa.nbusy, 2);
    ifa.bset = 1; ifa.bwa = 5'd6; ifa.we = 1; ifa.wa = 5'd2; ifa.wd = 32'h23; ifa.ra1 = 5'd6;
    tick();
    ifa.bset = 0; ifa.we = 0;
    #1;
    chk("t5_nbusy_cross", ifa.nbusy, 2);
    chk("t5_busy_r2_clr", ifa.busy0, 0);
    chk("t5_busy_r6_set", ifa.busy1, 1);

    // saturation on the small instance
    for (int i = 0; i < 8; i++) begin
      ifc.bset = 1; ifc.bwa = 3'(i);
      tick();
    end
    ifc.bset = 0;
    #1;
    chk("t6_nbusy_full", ifc.nbusy, 8);
    ifc.bset = 1; ifc.bwa = 3'd3;
    tick();
    ifc.bset = 0;
    #1;
    chk("t6_nbusy_extra_set", ifc.nbusy, 8);
    for (int i = 0; i < 8; i++) begin
      ifc.we = 1; ifc.wa = 3'(i); ifc.wd = 32'(32'h100 + i);
      tick();
      if (i == 2) chk("t6_nbusy_partial", ifc.nbusy, 5);
    end
    ifc.we = 0;
    #1;
    chk("t6_nbusy_empty", ifc.nbusy, 0);
    ifc.we = 1; ifc.wa = 3'd5; ifc.wd = 32'h55; ifc.ra0 = 3'd5; ifc.ra1 = 3'd6;
    tick();
    ifc.we = 0;
    #1;
    chk("t6_no_underflow", ifc.nbusy, 0);
    chk("t6_rd_r5", ifc.rd0, 32'h55);
    chk("t6_rd_r6", ifc.rd1, 32'h106);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
